// File: rtl/axi_lite_cmd_master.sv
// Issues one AXI-Lite read or write per accepted command and returns the result on a
// valid/ready response port; every AXI wait is bounded by TIMEOUT_CYCLES (0 = unbounded).
module axi_lite_cmd_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int STROBE_WIDTH   = DATA_WIDTH / 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                    i_axi_clk,
   input  logic                    i_axi_rst,
   input  logic                    i_cmd_valid,
   output logic                    o_cmd_ready,
   input  logic                    i_cmd_wr,
   input  logic [ADDR_WIDTH-1:0]   i_cmd_addr,
   input  logic [DATA_WIDTH-1:0]   i_cmd_data,
   input  logic [STROBE_WIDTH-1:0] i_cmd_strb,
   output logic                    o_rsp_valid,
   input  logic                    i_rsp_ready,
   output logic [DATA_WIDTH-1:0]   o_rsp_data,
   output logic [1:0]              o_rsp_resp,
   output logic                    o_rsp_timeout,
   output logic                    o_awvalid,
   output logic [ADDR_WIDTH-1:0]   o_awaddr,
   input  logic                    i_awready,
   output logic                    o_wvalid,
   output logic [DATA_WIDTH-1:0]   o_wdata,
   output logic [STROBE_WIDTH-1:0] o_wstrb,
   input  logic                    i_wready,
   input  logic                    i_bvalid,
   output logic                    o_bready,
   input  logic [1:0]              i_bresp,
   output logic                    o_arvalid,
   output logic [ADDR_WIDTH-1:0]   o_araddr,
   input  logic                    i_arready,
   input  logic                    i_rvalid,
   output logic                    o_rready,
   input  logic [1:0]              i_rresp,
   input  logic [DATA_WIDTH-1:0]   i_rdata
);

   // state     | meaning
   // S_IDLE    | ready for a command
   // S_WR_AW_W | write address and/or data still outstanding
   // S_WR_B    | waiting for the write response
   // S_RD_AR   | read address outstanding
   // S_RD_R    | waiting for read data
   // S_RSP     | response held until consumed
   typedef enum logic [2:0] {
      S_IDLE, S_WR_AW_W, S_WR_B, S_RD_AR, S_RD_R, S_RSP
   } state_t;

   // Counter must reach TIMEOUT_CYCLES itself: a handshake on the expiry cycle defers the check once.
   localparam int CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 2) : 1;
   localparam int CNT_LIM = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

   state_t                  state_q, state_d;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic                    cmd_ready_q, cmd_ready_d;
   logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
   logic                    bready_q, bready_d, arvalid_q, arvalid_d, rready_q, rready_d;
   logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d, rsp_data_q, rsp_data_d;
   logic [STROBE_WIDTH-1:0] wstrb_q, wstrb_d;
   logic                    rsp_valid_q, rsp_valid_d, rsp_timeout_q, rsp_timeout_d;
   logic [1:0]              rsp_resp_q, rsp_resp_d;
   logic                    aw_hs, w_hs, expired, abort;

   assign aw_hs   = awvalid_q & i_awready;
   assign w_hs    = wvalid_q & i_wready;
   assign expired = (TIMEOUT_CYCLES != 0) && (cnt_q >= CNT_W'(CNT_LIM));

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q + CNT_W'(1);
      cmd_ready_d   = cmd_ready_q;
      awvalid_d     = awvalid_q;
      awaddr_d      = awaddr_q;
      wvalid_d      = wvalid_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      bready_d      = bready_q;
      arvalid_d     = arvalid_q;
      araddr_d      = araddr_q;
      rready_d      = rready_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_data_d    = rsp_data_q;
      rsp_resp_d    = rsp_resp_q;
      rsp_timeout_d = rsp_timeout_q;
      abort         = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d       = '0;
            cmd_ready_d = 1'b1;
            if (cmd_ready_q && i_cmd_valid) begin
               cmd_ready_d = 1'b0;
               if (i_cmd_wr) begin
                  awvalid_d = 1'b1;
                  awaddr_d  = i_cmd_addr;
                  wvalid_d  = 1'b1;
                  wdata_d   = i_cmd_data;
                  wstrb_d   = i_cmd_strb;
                  state_d   = S_WR_AW_W;
               end else begin
                  arvalid_d = 1'b1;
                  araddr_d  = i_cmd_addr;
                  state_d   = S_RD_AR;
               end
            end
         end
         S_WR_AW_W: begin
            if (aw_hs) awvalid_d = 1'b0;
            if (w_hs)  wvalid_d  = 1'b0;
            if (!awvalid_d && !wvalid_d) begin
               bready_d = 1'b1;
               cnt_d    = '0;
               state_d  = S_WR_B;
            end else if (!aw_hs && !w_hs && expired) begin
               abort = 1'b1;
            end
         end
         S_WR_B: begin
            if (bready_q && i_bvalid) begin
               bready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_data_d    = '0;
               rsp_resp_d    = i_bresp;
               rsp_timeout_d = 1'b0;
               state_d       = S_RSP;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         S_RD_AR: begin
            if (arvalid_q && i_arready) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               cnt_d     = '0;
               state_d   = S_RD_R;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         S_RD_R: begin
            if (rready_q && i_rvalid) begin
               rready_d      = 1'b0;
               rsp_valid_d   = 1'b1;
               rsp_data_d    = i_rdata;
               rsp_resp_d    = i_rresp;
               rsp_timeout_d = 1'b0;
               state_d       = S_RSP;
            end else if (expired) begin
               abort = 1'b1;
            end
         end
         S_RSP: begin
            cnt_d = '0;
            if (i_rsp_ready) begin
               rsp_valid_d = 1'b0;
               cmd_ready_d = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (abort) begin
         awvalid_d     = 1'b0;
         wvalid_d      = 1'b0;
         bready_d      = 1'b0;
         arvalid_d     = 1'b0;
         rready_d      = 1'b0;
         rsp_valid_d   = 1'b1;
         rsp_data_d    = '0;
         rsp_resp_d    = 2'b11;
         rsp_timeout_d = 1'b1;
         cnt_d         = '0;
         state_d       = S_RSP;
      end
   end

   always_ff @(posedge i_axi_clk) begin
      if (i_axi_rst) begin
         state_q       <= S_IDLE;
         cnt_q         <= '0;
         cmd_ready_q   <= 1'b0;
         awvalid_q     <= 1'b0;
         awaddr_q      <= '0;
         wvalid_q      <= 1'b0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         bready_q      <= 1'b0;
         arvalid_q     <= 1'b0;
         araddr_q      <= '0;
         rready_q      <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_data_q    <= '0;
         rsp_resp_q    <= '0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_ready_q   <= cmd_ready_d;
         awvalid_q     <= awvalid_d;
         awaddr_q      <= awaddr_d;
         wvalid_q      <= wvalid_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         bready_q      <= bready_d;
         arvalid_q     <= arvalid_d;
         araddr_q      <= araddr_d;
         rready_q      <= rready_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_data_q    <= rsp_data_d;
         rsp_resp_q    <= rsp_resp_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign o_cmd_ready   = cmd_ready_q;
   assign o_awvalid     = awvalid_q;
   assign o_awaddr      = awaddr_q;
   assign o_wvalid      = wvalid_q;
   assign o_wdata       = wdata_q;
   assign o_wstrb       = wstrb_q;
   assign o_bready      = bready_q;
   assign o_arvalid     = arvalid_q;
   assign o_araddr      = araddr_q;
   assign o_rready      = rready_q;
   assign o_rsp_valid   = rsp_valid_q;
   assign o_rsp_data    = rsp_data_q;
   assign o_rsp_resp    = rsp_resp_q;
   assign o_rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Bench for axi_lite_cmd_master: delay-programmable slave, command-level reference
// model with per-cycle protocol checks, directed cases then randomized traffic.
module tb_axi_lite_cmd_master;
   localparam int T = 16;

   logic        i_axi_clk = 1'b0;
   logic        i_axi_rst;
   logic        i_cmd_valid, o_cmd_ready, i_cmd_wr;
   logic [31:0] i_cmd_addr, i_cmd_data;
   logic [3:0]  i_cmd_strb;
   logic        o_rsp_valid, i_rsp_ready, o_rsp_timeout;
   logic [31:0] o_rsp_data;
   logic [1:0]  o_rsp_resp;
   logic        o_awvalid, i_awready, o_wvalid, i_wready;
   logic [31:0] o_awaddr, o_wdata, o_araddr, i_rdata;
   logic [3:0]  o_wstrb;
   logic        i_bvalid, o_bready, o_arvalid, i_arready, i_rvalid, o_rready;
   logic [1:0]  i_bresp, i_rresp;

   always #5 i_axi_clk = ~i_axi_clk;

   axi_lite_cmd_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STROBE_WIDTH(4), .TIMEOUT_CYCLES(T)) dut (
      .i_axi_clk(i_axi_clk), .i_axi_rst(i_axi_rst),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
      .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data), .i_cmd_strb(i_cmd_strb),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
      .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
      .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
      .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
      .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
      .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
      .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // slave behaviour: cycles of valid before ready, and response codes
   int       aw_dly, w_dly, b_dly, ar_dly, r_dly;
   logic [1:0] b_resp, r_resp;
   bit       stray_en;
   logic [31:0] smem [16];
   logic [31:0] s_awaddr, s_wdata, s_araddr;
   logic [3:0]  s_wstrb;
   int       aw_c, w_c, b_c, ar_c, r_c;

   always @(posedge i_axi_clk) begin
      #1;
      if (o_awvalid) begin
         i_awready = (aw_c >= aw_dly); aw_c++;
         if (i_awready) s_awaddr = o_awaddr;
      end else begin i_awready = 1'b0; aw_c = 0; end
      if (o_wvalid) begin
         i_wready = (w_c >= w_dly); w_c++;
         if (i_wready) begin s_wdata = o_wdata; s_wstrb = o_wstrb; end
      end else begin i_wready = 1'b0; w_c = 0; end
      if (o_bready) begin
         i_bvalid = (b_c >= b_dly); i_bresp = b_resp; b_c++;
         if (i_bvalid)
            for (int i = 0; i < 4; i++)
               if (s_wstrb[i]) smem[s_awaddr[5:2]][8*i +: 8] = s_wdata[8*i +: 8];
      end else begin
         i_bvalid = stray_en && ($urandom_range(0, 1) == 1); i_bresp = 2'($urandom); b_c = 0;
      end
      if (o_arvalid) begin
         i_arready = (ar_c >= ar_dly); ar_c++;
         if (i_arready) s_araddr = o_araddr;
      end else begin i_arready = 1'b0; ar_c = 0; end
      if (o_rready) begin
         i_rvalid = (r_c >= r_dly); i_rresp = r_resp; i_rdata = smem[s_araddr[5:2]]; r_c++;
      end else begin
         i_rvalid = stray_en && ($urandom_range(0, 1) == 1); i_rresp = 2'($urandom); i_rdata = $urandom; r_c = 0;
      end
   end

   // command-level reference model
   typedef struct {
      bit wr; bit to; bit ar_to;
      logic [31:0] addr, data, rdata; logic [3:0] strb; logic [1:0] resp;
      int lat, aw_hi, w_hi, ar_hi;
   } exp_t;

   exp_t        e;
   logic [31:0] mmem [16];
   bit   armed = 0, busy = 0, rst_prev = 0, prev_rsp_valid = 0;
   bit   paw_pend = 0, pw_pend = 0, par_pend = 0, prsp_pend = 0;
   logic [31:0] paw_addr, pw_data, par_addr;
   logic [3:0]  pw_strb;
   logic [35:0] prsp;
   int   cyc = 0, cmd_cyc = 0, meas_lat = 0;
   int   aw_n, w_n, ar_n, aw_hi, w_hi, ar_hi;
   int   rsp_cnt = 0, last_lat, last_aw_hi, last_w_hi, last_ar_hi, last_w_n;
   logic [31:0] last_data;
   logic [1:0]  last_resp;
   logic        last_to;

   always @(negedge i_axi_clk) begin
      cyc++;
      if (armed) begin
         chk("cmd_ready", o_cmd_ready, !busy && !rst_prev);
         if (rst_prev)
            chk("reset_zero", |{o_awvalid, o_awaddr, o_wvalid, o_wdata, o_wstrb, o_bready, o_arvalid,
                                o_araddr, o_rready, o_rsp_valid, o_rsp_data, o_rsp_resp, o_rsp_timeout}, 0);
         if (o_rsp_valid) chk("rsp_only_when_busy", busy, 1);
         if (o_awvalid) aw_hi++;
         if (o_wvalid)  w_hi++;
         if (o_arvalid) ar_hi++;
         if (o_awvalid && i_awready) begin aw_n++; chk("aw_addr", o_awaddr, e.addr); end
         if (o_wvalid && i_wready) begin
            w_n++; chk("w_data", o_wdata, e.data); chk("w_strb", o_wstrb, e.strb);
         end
         if (o_arvalid && i_arready) begin ar_n++; chk("ar_addr", o_araddr, e.addr); end
         if (paw_pend) chk("aw_hold", (o_awvalid && o_awaddr == paw_addr) || (o_rsp_valid && o_rsp_timeout), 1);
         if (pw_pend)  chk("w_hold", (o_wvalid && o_wdata == pw_data && o_wstrb == pw_strb) || (o_rsp_valid && o_rsp_timeout), 1);
         if (par_pend) chk("ar_hold", (o_arvalid && o_araddr == par_addr) || (o_rsp_valid && o_rsp_timeout), 1);
         if (prsp_pend) chk("rsp_hold", {o_rsp_valid, o_rsp_data, o_rsp_resp, o_rsp_timeout}, {1'b1, prsp[34:0]});
         if (o_rsp_valid && !prev_rsp_valid && busy) begin
            meas_lat = cyc - cmd_cyc;
            if (!e.to) chk("latency", meas_lat, e.lat);
         end
         if (o_rsp_valid && i_rsp_ready && busy) begin
            chk("rsp_data", o_rsp_data, e.rdata);
            chk("rsp_resp", o_rsp_resp, e.resp);
            chk("rsp_timeout", o_rsp_timeout, e.to);
            if (!e.to && e.wr) begin
               chk("aw_count", aw_n, 1); chk("w_count", w_n, 1); chk("ar_count_wr", ar_n, 0);
               chk("aw_cycles", aw_hi, e.aw_hi); chk("w_cycles", w_hi, e.w_hi);
               for (int i = 0; i < 4; i++)
                  if (e.strb[i]) mmem[e.addr[5:2]][8*i +: 8] = e.data[8*i +: 8];
            end else if (!e.to) begin
               chk("ar_count", ar_n, 1); chk("aw_count_rd", aw_n + w_n, 0); chk("ar_cycles", ar_hi, e.ar_hi);
            end else if (!e.wr && e.ar_to) begin
               chk("ar_cycles_timeout", ar_hi, T);
            end
            rsp_cnt++;
            last_lat = meas_lat; last_data = o_rsp_data; last_resp = o_rsp_resp; last_to = o_rsp_timeout;
            last_aw_hi = aw_hi; last_w_hi = w_hi; last_ar_hi = ar_hi; last_w_n = w_n;
         end
      end
      if (armed && o_cmd_ready && i_cmd_valid && !i_axi_rst) begin
         e.wr = i_cmd_wr; e.addr = i_cmd_addr; e.data = i_cmd_data; e.strb = i_cmd_strb;
         e.aw_hi = aw_dly + 1; e.w_hi = w_dly + 1; e.ar_hi = ar_dly + 1;
         e.ar_to = (ar_dly >= T);
         if (i_cmd_wr) begin
            e.to    = (aw_dly >= T) || (w_dly >= T) || (b_dly >= T);
            e.lat   = 3 + ((aw_dly > w_dly) ? aw_dly : w_dly) + b_dly;
            e.rdata = '0; e.resp = b_resp;
         end else begin
            e.to    = (ar_dly >= T) || (r_dly >= T);
            e.lat   = 3 + ar_dly + r_dly;
            e.rdata = mmem[i_cmd_addr[5:2]]; e.resp = r_resp;
         end
         if (e.to) begin e.rdata = '0; e.resp = 2'b11; end
         cmd_cyc = cyc; aw_n = 0; w_n = 0; ar_n = 0; aw_hi = 0; w_hi = 0; ar_hi = 0;
      end
      paw_pend  = o_awvalid && !i_awready && !i_axi_rst; paw_addr = o_awaddr;
      pw_pend   = o_wvalid && !i_wready && !i_axi_rst;   pw_data = o_wdata; pw_strb = o_wstrb;
      par_pend  = o_arvalid && !i_arready && !i_axi_rst; par_addr = o_araddr;
      prsp_pend = o_rsp_valid && !i_rsp_ready && !i_axi_rst;
      prsp      = {1'b1, o_rsp_data, o_rsp_resp, o_rsp_timeout};
      prev_rsp_valid = o_rsp_valid;
      if (i_axi_rst) busy = 0;
      else if (armed && o_cmd_ready && i_cmd_valid) busy = 1;
      else if (armed && o_rsp_valid && i_rsp_ready) busy = 0;
      rst_prev = i_axi_rst;
      if (i_axi_rst) armed = 1;
   end

   task automatic set_dly(input int aw, input int w, input int b, input int ar, input int r);
      aw_dly = aw; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
   endtask

   task automatic send_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      int n = 0;
      i_cmd_valid = 1'b1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_data = data; i_cmd_strb = strb;
      while (!o_cmd_ready && n < 100) begin @(posedge i_axi_clk); #1; n++; end
      if (n >= 100) chk("cmd_accept_wait", 0, 1);
      @(posedge i_axi_clk); #1;
      i_cmd_valid = 1'b0; i_cmd_wr = 1'($urandom); i_cmd_addr = $urandom; i_cmd_data = $urandom; i_cmd_strb = 4'($urandom);
   endtask

   task automatic get_rsp(input int hold);
      int n = 0;
      while (!o_rsp_valid && n < 200) begin @(posedge i_axi_clk); #1; n++; end
      if (n >= 200) chk("rsp_wait", 0, 1);
      repeat (hold) begin @(posedge i_axi_clk); #1; end
      i_rsp_ready = 1'b1;
      @(posedge i_axi_clk); #1;
      i_rsp_ready = 1'b0;
   endtask

   task automatic do_cmd(input bit wr, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb, input int hold);
      send_cmd(wr, addr, data, strb);
      get_rsp(hold);
   endtask

   initial begin
      int rc, n;
      for (int i = 0; i < 16; i++) begin smem[i] = '0; mmem[i] = '0; end
      i_axi_rst = 1'b1; i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_data = '0;
      i_cmd_strb = '0; i_rsp_ready = 1'b0; i_awready = 1'b0; i_wready = 1'b0; i_bvalid = 1'b0;
      i_bresp = '0; i_arready = 1'b0; i_rvalid = 1'b0; i_rresp = '0; i_rdata = '0;
      stray_en = 0; b_resp = 2'b00; r_resp = 2'b00;
      set_dly(0, 0, 0, 0, 0);
      repeat (3) @(posedge i_axi_clk);
      #1; i_axi_rst = 1'b0;
      @(posedge i_axi_clk); #1;

      do_cmd(1, 32'h4, 32'hDEADBEEF, 4'hF, 0);
      chk("lit_wr_latency", last_lat, 3);
      chk("lit_wr_resp", {last_data, last_resp, last_to}, 0);
      do_cmd(0, 32'h4, 32'h0, 4'h0, 0);
      chk("lit_rd_data", last_data, 32'hDEADBEEF);
      chk("lit_rd_latency", last_lat, 3);

      set_dly(0, 5, 0, 0, 0);
      do_cmd(1, 32'h8, 32'h12345678, 4'hF, 0);
      chk("lit_aw_cycles", last_aw_hi, 1);
      chk("lit_w_cycles", last_w_hi, 6);
      chk("lit_w_count", last_w_n, 1);

      set_dly(0, 0, 0, 0, 0);
      do_cmd(0, 32'h8, 32'h0, 4'h0, 10);
      chk("lit_rd_hold_data", last_data, 32'h12345678);

      set_dly(0, 0, 0, 1000, 0);
      do_cmd(0, 32'h4, 32'h0, 4'h0, 0);
      chk("lit_to_resp", {last_data, last_resp, last_to}, {32'h0, 2'b11, 1'b1});
      chk("lit_to_ar_cycles", last_ar_hi, 16);
      set_dly(0, 0, 0, 0, 0);
      do_cmd(0, 32'h4, 32'h0, 4'h0, 0);
      chk("lit_after_to_data", last_data, 32'hDEADBEEF);

      set_dly(0, 0, 0, 15, 0);
      do_cmd(0, 32'h4, 32'h0, 4'h0, 0);
      chk("lit_ar15_no_timeout", last_to, 0);
      set_dly(0, 0, 0, 16, 0);
      do_cmd(0, 32'h4, 32'h0, 4'h0, 0);
      chk("lit_ar16_timeout", last_to, 1);
      set_dly(0, 0, 16, 0, 0);
      do_cmd(1, 32'h10, 32'hCAFEF00D, 4'hF, 0);
      chk("lit_b16_timeout", last_resp, 2'b11);

      set_dly(0, 0, 1000, 0, 0);
      send_cmd(1, 32'hC, 32'hA5A5A5A5, 4'hF);
      n = 0;
      while (!o_bready && n < 50) begin @(posedge i_axi_clk); #1; n++; end
      chk("reach_wr_b", o_bready, 1);
      rc = rsp_cnt;
      i_axi_rst = 1'b1;
      @(posedge i_axi_clk); #1;
      chk("lit_reset_bready", o_bready, 0);
      i_axi_rst = 1'b0;
      @(posedge i_axi_clk); #1;
      chk("lit_ready_after_reset", o_cmd_ready, 1);
      repeat (5) begin @(posedge i_axi_clk); #1; end
      chk("lit_no_rsp_after_reset", rsp_cnt, rc);
      set_dly(0, 0, 0, 0, 0);
      do_cmd(0, 32'hC, 32'h0, 4'h0, 0);
      chk("lit_aborted_write_absent", last_data, 0);

      stray_en = 1;
      for (int k = 0; k < 60; k++) begin
         set_dly($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 4));
         if ($urandom_range(0, 7) == 0)
            case ($urandom_range(0, 4))
               0: aw_dly = 20;
               1: w_dly  = 20;
               2: b_dly  = 20;
               3: ar_dly = 20;
               default: r_dly = 20;
            endcase
         b_resp = 2'($urandom_range(0, 3));
         r_resp = 2'($urandom_range(0, 3));
         do_cmd(1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2, $urandom,
                4'($urandom_range(1, 15)), $urandom_range(0, 4));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
